// File: rtl/vec_dot_scheduler.sv
// rtl/vec_dot_scheduler.sv - sequences a 4-lane 8x8 multiplier array to form an unsigned byte-vector dot product
module vec_dot_scheduler #(
    parameter int MUL_LAT = 3,
    parameter int LEN_W   = 10,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             in_valid,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             in_ready,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_issue,
    output logic [3:0]       mul_lane_en,
    input  logic [63:0]      mul_p,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] dot_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]        remaining;
    logic [1:0]              lane_idx;
    logic [31:0]             stg_a, stg_b;
    logic [3:0]              stg_en;
    logic [31:0]             grp_a, grp_b;
    logic [3:0]              grp_en;
    logic [MUL_LAT-1:0]      dl_v;
    logic [MUL_LAT-1:0]      dl_older;
    logic [3:0]              dl_en [MUL_LAT];
    logic [ACC_W-1:0]        acc;
    logic [17:0]             grp_sum;
    logic [ACC_W:0]          acc_sum;
    logic                    accept, last_pair, issue_now, acc_fire, job_start;

    assign accept    = in_valid && in_ready;
    assign last_pair = (remaining == LEN_W'(1));
    assign issue_now = accept && ((lane_idx == 2'd3) || last_pair);
    assign acc_fire  = dl_v[MUL_LAT-1];
    assign job_start = (state == S_IDLE) && start;
    // Entries behind the head: anything here means products are still on their way.
    assign dl_older  = dl_v << 1;

    // Group as it would look with the current pair dropped into its lane.
    always_comb begin
        grp_a = stg_a;
        grp_b = stg_b;
        grp_a[8*lane_idx +: 8] = in_a;
        grp_b[8*lane_idx +: 8] = in_b;
        grp_en = stg_en | (4'b0001 << lane_idx);
    end

    always_comb begin
        grp_sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (dl_en[MUL_LAT-1][i]) begin
                grp_sum = grp_sum + 18'(mul_p[16*i +: 16]);
            end
        end
        acc_sum = {1'b0, acc} + (ACC_W+1)'(grp_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (vec_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = (remaining != '0);
                if (in_valid && (remaining != '0) && last_pair) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!mul_issue && (dl_older == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining   <= '0;
            lane_idx    <= '0;
            stg_a       <= '0;
            stg_b       <= '0;
            stg_en      <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_issue   <= 1'b0;
            mul_lane_en <= '0;
            dl_v        <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                dl_en[i] <= '0;
            end
            acc         <= '0;
            overflow    <= 1'b0;
            dot_out     <= '0;
        end else begin
            mul_issue   <= issue_now;
            mul_lane_en <= issue_now ? grp_en : 4'b0000;

            // Issue and refill share the edge, so staging never stalls the stream.
            if (issue_now || job_start) begin
                if (issue_now) begin
                    mul_a <= grp_a;
                    mul_b <= grp_b;
                end
                stg_a    <= '0;
                stg_b    <= '0;
                stg_en   <= '0;
                lane_idx <= '0;
            end else if (accept) begin
                stg_a    <= grp_a;
                stg_b    <= grp_b;
                stg_en   <= grp_en;
                lane_idx <= lane_idx + 2'd1;
            end

            if (job_start) begin
                remaining <= vec_len;
            end else if (accept) begin
                remaining <= remaining - LEN_W'(1);
            end

            dl_v[0]  <= mul_issue;
            dl_en[0] <= mul_lane_en;
            for (int i = 1; i < MUL_LAT; i++) begin
                dl_v[i]  <= dl_v[i-1];
                dl_en[i] <= dl_en[i-1];
            end

            if (job_start) begin
                acc      <= '0;
                overflow <= 1'b0;
            end else if (acc_fire) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    overflow <= 1'b1;
                end
            end

            if (job_start && (vec_len == '0)) begin
                dot_out <= '0;
            end else if ((state == S_DRAIN) && (state_nxt == S_DONE)) begin
                dot_out <= acc_fire ? acc_sum[ACC_W-1:0] : acc;
            end
        end
    end

endmodule

// File: tb/tb_vec_dot_scheduler.sv
// tb/tb_vec_dot_scheduler.sv - scoreboard bench for vec_dot_scheduler with a 3-stage multiplier array model
module tb_vec_dot_scheduler;

    localparam int MUL_LAT = 3;
    localparam int LEN_W   = 10;
    localparam int ACC_W   = 24;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             in_ready;
    logic [31:0]      mul_a, mul_b;
    logic             mul_issue;
    logic [3:0]       mul_lane_en;
    logic [63:0]      mul_p;
    logic             busy, done, overflow;
    logic [ACC_W-1:0] dot_out;

    vec_dot_scheduler #(.MUL_LAT(MUL_LAT), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_issue(mul_issue), .mul_lane_en(mul_lane_en),
        .mul_p(mul_p), .busy(busy), .done(done), .dot_out(dot_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // External array: three register stages of per-lane 8x8 products.
    logic [63:0] p1, p2, p3;
    function automatic logic [63:0] lane_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
        return r;
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= '0; p2 <= '0; p3 <= '0;
        end else begin
            p1 <= lane_mul(mul_a, mul_b); p2 <= p1; p3 <= p2;
        end
    end
    assign mul_p = p3;

    typedef struct { logic [3:0] en; logic [31:0] a; logic [31:0] b; } issue_t;
    typedef struct { logic [ACC_W-1:0] dot; logic ovf; } res_t;
    issue_t iss_q[$];
    res_t   res_q[$];
    logic [7:0] a_v[$];
    logic [7:0] b_v[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (mul_issue) begin
                if (iss_q.size() == 0) chk("stray_issue", 1, 0);
                else begin
                    issue_t e;
                    e = iss_q.pop_front();
                    chk("issue_lane_en", mul_lane_en, e.en);
                    chk("issue_mul_a", mul_a, e.a);
                    chk("issue_mul_b", mul_b, e.b);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (res_q.size() == 0) chk("stray_done", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("dot_out", dot_out, r.dot);
                    chk("overflow", overflow, r.ovf);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
        chk({tag, "_mul_issue"}, mul_issue, 0);
        chk({tag, "_mul_lane_en"}, mul_lane_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dot_out"}, dot_out, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic run_job(input int len, input bit gaps, input bit pulse_start, input bit abort);
        longint total;
        res_t r;
        int s_cyc, l_cyc, k, guard, start_cnt;
        bit gap_ph;
        total = 0;
        for (int i = 0; i < len; i++) total += longint'(a_v[i]) * longint'(b_v[i]);
        r.dot = total[ACC_W-1:0];
        r.ovf = (total >= (longint'(1) << ACC_W));
        res_q.push_back(r);
        for (int g = 0; g < (len + 3) / 4; g++) begin
            issue_t e;
            e.en = '0; e.a = '0; e.b = '0;
            for (int l = 0; l < 4; l++) begin
                if (4*g + l < len) begin
                    e.en[l] = 1'b1;
                    e.a[8*l +: 8] = a_v[4*g + l];
                    e.b[8*l +: 8] = b_v[4*g + l];
                end
            end
            iss_q.push_back(e);
        end

        @(negedge clk);
        start = 1'b1;
        vec_len = LEN_W'(len);
        s_cyc = cyc;
        start_cnt = done_cnt;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, (len != 0));

        k = 0; l_cyc = s_cyc; guard = 0; gap_ph = 1'b0;
        while (k < len && guard < 2000) begin
            guard++;
            start = pulse_start && (k == 1);
            if (start) vec_len = LEN_W'(3);
            if (gaps && gap_ph) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_a = a_v[k];
                in_b = b_v[k];
            end
            gap_ph = !gap_ph;
            #1;
            if (in_valid && in_ready) begin
                l_cyc = cyc;
                k++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (k < len) chk("feed_timeout", k, len);

        if (abort) begin
            @(negedge clk);
            @(negedge clk);
            chk("busy_in_drain", busy, 1);
            #2 reset = 1'b1;
            #1 check_reset_outputs("abort");
            iss_q.delete();
            res_q.delete();
            repeat (3) @(negedge clk);
            reset = 1'b0;
            return;
        end

        guard = 0;
        while (done_cnt == start_cnt && guard < len + 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (done_cnt == start_cnt) chk("done_timeout", 0, 1);
        else if (len == 0) chk("done_latency_len0", done_cyc - s_cyc, 1);
        else chk("done_latency", done_cyc - l_cyc, 2 + MUL_LAT);
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic load_seq(input int len, input int mode);
        a_v.delete();
        b_v.delete();
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: begin a_v.push_back(8'(i + 1)); b_v.push_back(8'(i + 5)); end
                1: begin a_v.push_back(8'(i + 1)); b_v.push_back(8'd2); end
                2: begin a_v.push_back(8'hFF); b_v.push_back(8'hFF); end
                default: begin a_v.push_back(8'($urandom_range(0, 255))); b_v.push_back(8'($urandom_range(0, 255))); end
            endcase
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        reset = 1'b0;

        load_seq(4, 0);
        run_job(4, 1'b0, 1'b0, 1'b0);

        load_seq(4, 0);
        a_v.push_back(8'd10);
        b_v.push_back(8'd10);
        run_job(5, 1'b0, 1'b0, 1'b0);

        load_seq(6, 1);
        run_job(6, 1'b1, 1'b0, 1'b0);

        load_seq(0, 0);
        run_job(0, 1'b0, 1'b0, 1'b0);

        load_seq(260, 2);
        run_job(260, 1'b0, 1'b0, 1'b0);

        load_seq(13, 3);
        run_job(13, 1'b0, 1'b0, 1'b0);

        load_seq(8, 1);
        run_job(8, 1'b0, 1'b0, 1'b1);

        load_seq(4, 0);
        run_job(4, 1'b0, 1'b1, 1'b0);

        repeat (10) @(negedge clk);
        chk("iss_q_drained", iss_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
